mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS CPU; sits in EX beside the combinational ALU.
- The ALU computes single-cycle results. This block is the multi-cycle partner: it takes an operation, holds it for a fixed latency, and reports completion through `busy`.
- Hazard logic stalls on (start | busy) when an MD instruction reaches EX.

---
 rtl/mdu_hilo_pkg.sv | 57 +++++
 rtl/mdu_hilo.sv | 167 ++++++++++++++++
 tb/tb_mdu_hilo.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared operation codes, default latencies and helpers for the
// multiply/divide unit. The accumulate codes (MADD/MSUB) are only honoured by
// the unit when MDU_MADD_EN is defined; otherwise codes 6/7 are no-ops.
package mdu_hilo_pkg;

  localparam int unsigned MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 3'd6;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 3'd7;

  // Default latencies; the hazard unit uses the same numbers to size stalls.
  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  // What happens to HI/LO when the in-flight operation completes.
  typedef enum logic [1:0] {
    PEND_LOAD,
    PEND_KEEP,
    PEND_ADD,
    PEND_SUB
  } pend_kind_e;

  // Controller states: idle accepts new work, busy counts down to completion.
  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

  // Signed 32/32 divide returning {remainder, quotient}. Works on magnitudes so
  // the quotient truncates toward zero, the remainder follows the dividend's
  // sign, and 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  function automatic logic [63:0] signed_divmod(input logic [31:0] a,
                                                input logic [31:0] b);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot;
    logic [31:0] rem;
    neg_a = a[31];
    neg_b = b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    quot  = mag_a / mag_b;
    rem   = mag_a % mag_b;
    if (neg_a ^ neg_b) quot = ~quot + 32'd1;
    if (neg_a)         rem  = ~rem + 32'd1;
    return {rem, quot};
  endfunction

endpackage

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed when the operation is accepted, parked in a pending
// register, and committed to HI/LO when a single down-counter expires.
// Optional feature: define MDU_MADD_EN to accept MADD/MSUB (codes 6/7), which
// accumulate a signed product into {HI,LO} at completion.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  output logic               busy,
  output logic [31:0]        HI,
  output logic [31:0]        LO
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        state_q, state_d;
  pend_kind_e       kind_q, kind_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        launch;
  logic        last;
  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] div_s;
  logic [63:0] div_u;

  assign last = (count_q == CNT_ONE);

  // Operand arithmetic evaluated every cycle; only captured on an accepted start.
  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, A} * {32'd0, B};
    div_s  = 64'd0;
    div_u  = 64'd0;
    if (B != 32'd0) begin
      div_s = signed_divmod(A, B);
      div_u = {A % B, A / B};
    end
  end

  // Datapath: capture pending result on launch, count down, commit on expiry.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    pend_d  = pend_q;
    kind_d  = kind_q;
    launch  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        case (md_op)
          MD_MULT: begin
            pend_d  = prod_s;
            kind_d  = PEND_LOAD;
            count_d = MUL_CNT;
            launch  = 1'b1;
          end
          MD_MULTU: begin
            pend_d  = prod_u;
            kind_d  = PEND_LOAD;
            count_d = MUL_CNT;
            launch  = 1'b1;
          end
          MD_DIV: begin
            pend_d  = div_s;
            kind_d  = (B == 32'd0) ? PEND_KEEP : PEND_LOAD;
            count_d = DIV_CNT;
            launch  = 1'b1;
          end
          MD_DIVU: begin
            pend_d  = div_u;
            kind_d  = (B == 32'd0) ? PEND_KEEP : PEND_LOAD;
            count_d = DIV_CNT;
            launch  = 1'b1;
          end
          MD_MTHI: hi_d = A;
          MD_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
          MD_MADD: begin
            pend_d  = prod_s;
            kind_d  = PEND_ADD;
            count_d = MUL_CNT;
            launch  = 1'b1;
          end
          MD_MSUB: begin
            pend_d  = prod_s;
            kind_d  = PEND_SUB;
            count_d = MUL_CNT;
            launch  = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end else begin
      count_d = count_q - CNT_ONE;
      if (last) begin
        case (kind_q)
          PEND_LOAD: {hi_d, lo_d} = pend_q;
`ifdef MDU_MADD_EN
          PEND_ADD:  {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
          PEND_SUB:  {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
`endif
          default: ;
        endcase
      end
    end
  end

  // Next-state: go busy on an accepted multi-cycle op, return idle on expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_BUSY;
      ST_BUSY: if (last)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: busy reflects the registered state, HI/LO are plain registers.
  always_comb begin
    busy = (state_q == ST_BUSY);
    HI   = hi_q;
    LO   = lo_q;
  end

  // State registers with synchronous active-low reset; reset abandons any op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      kind_q  <= PEND_LOAD;
      count_q <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed bench for mdu_hilo. A transaction-level model predicts
// busy/HI/LO each cycle from issue and completion times; literal checks pin it.
// Define MDU_MADD_EN for both bench and RTL to exercise MADD/MSUB.
module tb_mdu_hilo;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit check_en = 1'b0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          m_inflight = 1'b0;
  logic [2:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  int          m_start_at;
  int          m_done_at;

  mdu_hilo #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (a_in),
    .B     (b_in),
    .busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Architectural effect of one completed operation on HI/LO.
  task automatic modelApply(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, inout logic [31:0] h,
                            inout logic [31:0] l);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin wide = 64'(sa * sb); {h, l} = wide; end
      3'd1: begin wide = {32'd0, a} * {32'd0, b}; {h, l} = wide; end
      3'd2: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        l = q[31:0];
        h = r[31:0];
      end
      3'd3: if (b != 0) begin
        l = a / b;
        h = a % b;
      end
      3'd4: h = a;
      3'd5: l = a;
`ifdef MDU_MADD_EN
      3'd6: begin wide = {h, l} + 64'(sa * sb); {h, l} = wide; end
      3'd7: begin wide = {h, l} - 64'(sa * sb); {h, l} = wide; end
`endif
      default: ;
    endcase
  endtask

  // Compare process: retire due operations in the model, then check the DUT.
  always @(negedge clk) begin
    cyc++;
    if (m_inflight && cyc >= m_done_at) begin
      modelApply(m_op, m_a, m_b, m_hi, m_lo);
      m_inflight = 1'b0;
    end
    if (check_en) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, (m_inflight && cyc >= m_start_at)});
      checkOutput("hi", hi, m_hi);
      checkOutput("lo", lo, m_lo);
    end
  end

  // Issue one start pulse; the model records it only if the DUT should accept it.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    int lat;
    @(negedge clk);
    #1;
    start = 1'b1;
    md_op = op;
    a_in  = a;
    b_in  = b;
    if (!m_inflight && (op <= 3'd5 || MADD_EN)) begin
      if (op == 3'd2 || op == 3'd3) lat = DIV_N;
      else if (op == 3'd4 || op == 3'd5) lat = 0;
      else lat = MUL_N;
      m_op       = op;
      m_a        = a;
      m_b        = b;
      m_start_at = cyc + 1;
      m_done_at  = cyc + 1 + lat;
      m_inflight = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulseReset(input int n);
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      m_hi = '0;
      m_lo = '0;
      m_inflight = 1'b0;
    end
    reset = 1'b1;
  endtask

  // Count cycles busy stays high; ends at the first negedge with busy low.
  task automatic waitIdle(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    checkOutput("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    md_op = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    applyStimulus(3'd0, 32'hFFFFFFFE, 32'd3);
    waitIdle(n);
    checkOutput("mult_len", n, MUL_N);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFFA);

    applyStimulus(3'd1, 32'hFFFFFFFF, 32'd2);
    waitIdle(n);
    checkOutput("multu_len", n, MUL_N);
    checkOutput("multu_hi", hi, 32'h00000001);
    checkOutput("multu_lo", lo, 32'hFFFFFFFE);

    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
    waitIdle(n);
    checkOutput("div_len", n, DIV_N);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);

    applyStimulus(3'd3, 32'd7, 32'd2);
    waitIdle(n);
    checkOutput("divu_lo", lo, 32'd3);
    checkOutput("divu_hi", hi, 32'd1);

    applyStimulus(3'd2, 32'd7, 32'hFFFFFFFE);
    waitIdle(n);
    checkOutput("div_negb_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_negb_hi", hi, 32'd1);

    applyStimulus(3'd4, 32'h1234, 32'd0);
    @(negedge clk);
    checkOutput("mthi_hi", hi, 32'h1234);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(3'd5, 32'h5678, 32'd0);
    @(negedge clk);
    checkOutput("mtlo_lo", lo, 32'h5678);

    applyStimulus(3'd3, 32'd99, 32'd0);
    repeat (2) @(negedge clk);
    applyStimulus(3'd4, 32'hAAAA, 32'd0);
    waitIdle(n);
    checkOutput("div0_len", n, DIV_N - 3);
    checkOutput("div0_hi", hi, 32'h1234);
    checkOutput("div0_lo", lo, 32'h5678);

    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
    waitIdle(n);
    checkOutput("ovf_lo", lo, 32'h80000000);
    checkOutput("ovf_hi", hi, 32'h0);

`ifndef MDU_MADD_EN
    applyStimulus(3'd6, 32'd3, 32'd4);
    @(negedge clk);
    checkOutput("rsvd_busy", {31'd0, busy}, 32'd0);
    checkOutput("rsvd_lo", lo, 32'h80000000);
`endif

    applyStimulus(3'd0, 32'd6, 32'd7);
    @(negedge clk);
    pulseReset(1);
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_hi", hi, 32'h0);
    checkOutput("abort_lo", lo, 32'h0);

`ifdef MDU_MADD_EN
    applyStimulus(3'd5, 32'd10, 32'd0);
    applyStimulus(3'd6, 32'd3, 32'd4);
    waitIdle(n);
    checkOutput("madd_len", n, MUL_N);
    checkOutput("madd_lo", lo, 32'd22);
    checkOutput("madd_hi", hi, 32'd0);
    applyStimulus(3'd7, 32'd5, 32'd10);
    waitIdle(n);
    checkOutput("msub_lo", lo, 32'hFFFFFFE4);
    checkOutput("msub_hi", hi, 32'hFFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
